// File: rtl/ex_operand_stage.sv
// ID/EX operand stage in front of the integer ALU.
// Captures one decoded instruction, resolves EX/MEM/WB operand forwarding,
// stalls on load-use hazards and prepares 32-bit W-op shift operands.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid / in_ready         upstream handshake (in_ready is combinational)
//   rs1/rs2_addr, rs1/rs2_data  source indices and register-file data
//   imm, alusrc                 immediate and b-operand select
//   alu_ctrl_in, w_arith_in     ALU opcode and 32-bit op flag
//   rd_in, reg_write_in, is_load_in  destination info
//   flush                       kill held and incoming instruction
//   ex_result                   ALU result of the held instruction
//   fwd_mem_*, fwd_wb_*         later-stage writeback for forwarding
//   out_valid / out_ready       downstream handshake
//   a, b, ALUControl, w_arith, rd, reg_write, is_load  registered outputs
module ex_operand_stage #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   rs1_addr,
    input  logic [4:0]   rs2_addr,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    input  logic         alusrc,
    input  logic [3:0]   alu_ctrl_in,
    input  logic         w_arith_in,
    input  logic [4:0]   rd_in,
    input  logic         reg_write_in,
    input  logic         is_load_in,
    input  logic         flush,
    input  logic [N-1:0] ex_result,
    input  logic         fwd_mem_valid,
    input  logic [4:0]   fwd_mem_rd,
    input  logic [N-1:0] fwd_mem_data,
    input  logic         fwd_wb_valid,
    input  logic [4:0]   fwd_wb_rd,
    input  logic [N-1:0] fwd_wb_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   ALUControl,
    output logic         w_arith,
    output logic [4:0]   rd,
    output logic         reg_write,
    output logic         is_load
);

    localparam int unsigned RW = 5;
    localparam int unsigned HW = 32;
    localparam logic [3:0] OP_W_ZEXT = 4'b0011;
    localparam logic [3:0] OP_W_SEXT = 4'b1011;

    logic         hazard_c;
    logic         capture_c;
    logic         ex_fwd_ok_c;
    logic         out_valid_nxt;
    logic [N-1:0] rs1_fwd;
    logic [N-1:0] rs2_fwd;
    logic [N-1:0] a_nxt;
    logic [N-1:0] b_nxt;

    // Forwarding mux: youngest producer wins, x0 always reads the register file.
    function automatic logic [N-1:0] fwd_sel(
        input logic [RW-1:0] rs,
        input logic [N-1:0]  rf,
        input logic          ex_ok,
        input logic [RW-1:0] ex_rd,
        input logic [N-1:0]  ex_val,
        input logic          mem_v,
        input logic [RW-1:0] mem_rd,
        input logic [N-1:0]  mem_val,
        input logic          wb_v,
        input logic [RW-1:0] wb_rd,
        input logic [N-1:0]  wb_val
    );
        logic [N-1:0] res;
        res = rf;
        if (rs != '0) begin
            if (ex_ok && ex_rd == rs)
                res = ex_val;
            else if (mem_v && mem_rd == rs)
                res = mem_val;
            else if (wb_v && wb_rd == rs)
                res = wb_val;
        end
        return res;
    endfunction

    // Load result is not available in EX yet: the consumer waits one cycle.
    assign hazard_c = out_valid && is_load && (rd != '0) &&
                      ((rs1_addr == rd) || (!alusrc && (rs2_addr == rd)));

    assign in_ready  = flush || ((!out_valid || out_ready) && !hazard_c);
    assign capture_c = in_valid && in_ready && !flush;

    // Loads only have an address in ex_result, so they never forward from EX.
    assign ex_fwd_ok_c = out_valid && reg_write && !is_load;

    // Operand selection and W-op preparation for the incoming instruction.
    always_comb begin
        rs1_fwd = fwd_sel(rs1_addr, rs1_data, ex_fwd_ok_c, rd, ex_result,
                          fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        rs2_fwd = fwd_sel(rs2_addr, rs2_data, ex_fwd_ok_c, rd, ex_result,
                          fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        a_nxt = rs1_fwd;
        if (w_arith_in && alu_ctrl_in == OP_W_ZEXT)
            a_nxt = {{(N-HW){1'b0}}, rs1_fwd[HW-1:0]};
        else if (w_arith_in && alu_ctrl_in == OP_W_SEXT)
            a_nxt = {{(N-HW){rs1_fwd[HW-1]}}, rs1_fwd[HW-1:0]};
        b_nxt = alusrc ? imm : rs2_fwd;
    end

    // Valid tracking: flush, then load-use bubble, then capture, then drain.
    always_comb begin
        out_valid_nxt = out_valid;
        if (flush)
            out_valid_nxt = 1'b0;
        else if (hazard_c && out_ready)
            out_valid_nxt = 1'b0;
        else if (capture_c)
            out_valid_nxt = 1'b1;
        else if (out_valid && out_ready)
            out_valid_nxt = 1'b0;
    end

    // Payload registers only load on capture so a stalled instruction holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            ALUControl <= '0;
            w_arith    <= 1'b0;
            rd         <= '0;
            reg_write  <= 1'b0;
            is_load    <= 1'b0;
        end else begin
            out_valid <= out_valid_nxt;
            if (capture_c) begin
                a          <= a_nxt;
                b          <= b_nxt;
                ALUControl <= alu_ctrl_in;
                w_arith    <= w_arith_in;
                rd         <= rd_in;
                reg_write  <= reg_write_in;
                is_load    <= is_load_in;
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_ex_operand_stage;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   rs1_addr, rs2_addr;
    logic [N-1:0] rs1_data, rs2_data, imm;
    logic         alusrc;
    logic [3:0]   alu_ctrl_in;
    logic         w_arith_in;
    logic [4:0]   rd_in;
    logic         reg_write_in, is_load_in;
    logic         flush;
    logic [N-1:0] ex_result;
    logic         fwd_mem_valid;
    logic [4:0]   fwd_mem_rd;
    logic [N-1:0] fwd_mem_data;
    logic         fwd_wb_valid;
    logic [4:0]   fwd_wb_rd;
    logic [N-1:0] fwd_wb_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] a, b;
    logic [3:0]   ALUControl;
    logic         w_arith;
    logic [4:0]   rd;
    logic         reg_write, is_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .alusrc(alusrc),
        .alu_ctrl_in(alu_ctrl_in), .w_arith_in(w_arith_in),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .is_load_in(is_load_in),
        .flush(flush), .ex_result(ex_result),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .ALUControl(ALUControl), .w_arith(w_arith),
        .rd(rd), .reg_write(reg_write), .is_load(is_load)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
        logic        w;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
    } instr_t;

    instr_t held[$];   // the instruction sitting in the stage, if any

    // Candidate values ordered youngest producer first; register file last.
    function automatic logic [63:0] ref_operand(input logic [4:0] rs, input logic [63:0] rf);
        logic [63:0] cands[$];
        if (rs == 5'd0) return rf;
        if (held.size() == 1 && held[0].rw && !held[0].ld && held[0].rd == rs)
            cands.push_back(ex_result);
        if (fwd_mem_valid && fwd_mem_rd == rs) cands.push_back(fwd_mem_data);
        if (fwd_wb_valid && fwd_wb_rd == rs) cands.push_back(fwd_wb_data);
        cands.push_back(rf);
        return cands[0];
    endfunction

    function automatic instr_t ref_capture();
        instr_t r;
        r.a = ref_operand(rs1_addr, rs1_data);
        if (w_arith_in && alu_ctrl_in == 4'b0011)
            r.a = r.a & 64'h0000_0000_FFFF_FFFF;
        else if (w_arith_in && alu_ctrl_in == 4'b1011)
            r.a = 64'($signed(r.a[31:0]));
        r.b    = alusrc ? imm : ref_operand(rs2_addr, rs2_data);
        r.ctrl = alu_ctrl_in;
        r.w    = w_arith_in;
        r.rd   = rd_in;
        r.rw   = reg_write_in;
        r.ld   = is_load_in;
        return r;
    endfunction

    function automatic bit ref_load_use();
        if (held.size() != 1 || !held[0].ld || held[0].rd == 5'd0) return 1'b0;
        return (rs1_addr == held[0].rd) || (!alusrc && rs2_addr == held[0].rd);
    endfunction

    function automatic bit ref_ready();
        return flush || ((held.size() == 0 || out_ready) && !ref_load_use());
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        instr_t nw;
        bit lu, rdy;
        nw  = ref_capture();
        lu  = ref_load_use();
        rdy = ref_ready();
        if (flush) held.delete();
        else if (lu && out_ready) held.delete();
        else if (in_valid && rdy) begin
            held.delete();
            held.push_back(nw);
        end else if (out_ready) held.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
        imm = 0; alusrc = 0; alu_ctrl_in = 0; w_arith_in = 0; rd_in = 0;
        reg_write_in = 0; is_load_in = 0; flush = 0; ex_result = 0;
        fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0; out_ready = 1;
    endtask

    task automatic idle();
        clear_inputs();
        tick();
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] im,
                         input logic src, input logic [3:0] ctrl, input logic w,
                         input logic [4:0] dst, input logic rw, input logic ld);
        in_valid = 1; rs1_addr = r1; rs2_addr = r2; rs1_data = d1; rs2_data = d2;
        imm = im; alusrc = src; alu_ctrl_in = ctrl; w_arith_in = w;
        rd_in = dst; reg_write_in = rw; is_load_in = ld;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || a !== '0 || b !== '0 || ALUControl !== 4'b0 ||
            w_arith !== 1'b0 || rd !== 5'd0 || reg_write !== 1'b0 || is_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: v=%b a=%h b=%h ctrl=%b w=%b rd=%0d rw=%b ld=%b, expected all zero",
                     out_valid, a, b, ALUControl, w_arith, rd, reg_write, is_load);
        end
        @(negedge clk);
        reset = 0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_pass_through();
        idle();
        issue(5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 1'b0, 4'b0010, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || a !== 64'd5 || b !== 64'd7 || ALUControl !== 4'b0010) begin
            errors++;
            $display("FAIL pass_through: v=%b a=%h b=%h ctrl=%b, expected v=1 a=5 b=7 ctrl=0010",
                     out_valid, a, b, ALUControl);
        end
        in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_priority();
        idle();
        issue(5'd0, 5'd0, 64'd0, 64'd0, 64'd16, 1'b1, 4'b0010, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        issue(5'd1, 5'd1, 64'h99, 64'h99, 64'd0, 1'b0, 4'b0010, 1'b0, 5'd2, 1'b1, 1'b0);
        ex_result = 64'h10;
        fwd_mem_valid = 1; fwd_mem_rd = 5'd1; fwd_mem_data = 64'h20;
        fwd_wb_valid = 1; fwd_wb_rd = 5'd1; fwd_wb_data = 64'h30;
        tick();
        checks++;
        if (a !== 64'h10 || b !== 64'h10) begin
            errors++;
            $display("FAIL prio_ex: a=%h b=%h expected 10/10", a, b);
        end
        tick();
        checks++;
        if (a !== 64'h20 || b !== 64'h20) begin
            errors++;
            $display("FAIL prio_mem: a=%h b=%h expected 20/20", a, b);
        end
        fwd_mem_valid = 0;
        tick();
        checks++;
        if (a !== 64'h30 || b !== 64'h30) begin
            errors++;
            $display("FAIL prio_wb: a=%h b=%h expected 30/30", a, b);
        end
        // x0 must never pick up a forwarded value
        fwd_wb_valid = 0;
        fwd_mem_valid = 1; fwd_mem_rd = 5'd0; fwd_mem_data = 64'hFF;
        issue(5'd0, 5'd3, 64'd0, 64'd4, 64'd0, 1'b0, 4'b0010, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        checks++;
        if (a !== 64'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL x0_no_fwd: a=%h v=%b expected a=0 v=1", a, out_valid);
        end
    endtask

    task automatic test_load_use();
        idle();
        issue(5'd1, 5'd0, 64'h1000, 64'd0, 64'd8, 1'b1, 4'b0010, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(5'd5, 5'd1, 64'h11, 64'h22, 64'd0, 1'b0, 4'b0010, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: out_valid=%b expected 0", out_valid);
        end
        fwd_mem_valid = 1; fwd_mem_rd = 5'd5; fwd_mem_data = 64'hAB;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: in_ready=%b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || a !== 64'hAB || b !== 64'h22) begin
            errors++;
            $display("FAIL load_use_fwd: v=%b a=%h b=%h expected v=1 a=ab b=22", out_valid, a, b);
        end
        // rs2 names the load target but the immediate is used: no stall
        fwd_mem_valid = 0;
        issue(5'd1, 5'd0, 64'h1000, 64'd0, 64'd8, 1'b1, 4'b0010, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(5'd1, 5'd5, 64'h33, 64'h44, 64'h40, 1'b1, 4'b0010, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL imm_no_hazard: in_ready=%b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || a !== 64'h33 || b !== 64'h40) begin
            errors++;
            $display("FAIL imm_capture: v=%b a=%h b=%h expected v=1 a=33 b=40", out_valid, a, b);
        end
    endtask

    task automatic test_w_op();
        idle();
        issue(5'd3, 5'd4, 64'h0000_0000_8000_0000, 64'd1, 64'd0, 1'b0, 4'b1011, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        checks++;
        if (a !== 64'hFFFF_FFFF_8000_0000 || w_arith !== 1'b1) begin
            errors++;
            $display("FAIL w_sext: a=%h w=%b expected ffffffff80000000 w=1", a, w_arith);
        end
        issue(5'd3, 5'd4, 64'hFFFF_FFFF_8000_0010, 64'd1, 64'd0, 1'b0, 4'b0011, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        checks++;
        if (a !== 64'h0000_0000_8000_0010) begin
            errors++;
            $display("FAIL w_zext: a=%h expected 0000000080000010", a);
        end
    endtask

    task automatic test_backpressure_flush_reset();
        idle();
        issue(5'd3, 5'd4, 64'h1234, 64'h5678, 64'd0, 1'b0, 4'b0110, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        out_ready = 0;
        issue(5'd3, 5'd4, 64'hDEAD, 64'hBEEF, 64'd0, 1'b0, 4'b0001, 1'b0, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: in_ready=%b expected 0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || a !== 64'h1234 || b !== 64'h5678 ||
                ALUControl !== 4'b0110 || rd !== 5'd7) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b a=%h b=%h ctrl=%b rd=%0d expected 1/1234/5678/0110/7",
                         i, out_valid, a, b, ALUControl, rd);
            end
        end
        flush = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: out_valid=%b expected 0", out_valid);
        end
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_capture: out_valid=%b expected 0", out_valid);
        end
        // asynchronous reset while an instruction is held
        issue(5'd3, 5'd4, 64'h55, 64'h66, 64'd0, 1'b0, 4'b0101, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        in_valid = 0; out_ready = 0;
        #3;
        reset = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || a !== '0 || b !== '0 || ALUControl !== 4'b0 ||
            w_arith !== 1'b0 || rd !== 5'd0 || reg_write !== 1'b0 || is_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: v=%b a=%h b=%h ctrl=%b w=%b rd=%0d rw=%b ld=%b expected all zero",
                     out_valid, a, b, ALUControl, w_arith, rd, reg_write, is_load);
        end
        #1;
        reset = 0;
        out_ready = 1;
        tick();
    endtask

    task automatic test_random();
        idle();
        held.delete();
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            rs1_addr      = 5'($urandom_range(0, 3));
            rs2_addr      = 5'($urandom_range(0, 3));
            rs1_data      = (rs1_addr == 5'd0) ? 64'd0 : {$urandom, $urandom};
            rs2_data      = (rs2_addr == 5'd0) ? 64'd0 : {$urandom, $urandom};
            imm           = {$urandom, $urandom};
            alusrc        = 1'($urandom_range(0, 1));
            alu_ctrl_in   = ($urandom_range(0, 1) != 0) ?
                            (($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1011) : 4'($urandom);
            w_arith_in    = 1'($urandom_range(0, 1));
            rd_in         = 5'($urandom_range(0, 3));
            reg_write_in  = 1'($urandom_range(0, 1));
            is_load_in    = ($urandom_range(0, 2) == 0);
            ex_result     = {$urandom, $urandom};
            fwd_mem_valid = 1'($urandom_range(0, 1));
            fwd_mem_rd    = 5'($urandom_range(0, 3));
            fwd_mem_data  = {$urandom, $urandom};
            fwd_wb_valid  = 1'($urandom_range(0, 1));
            fwd_wb_rd     = 5'($urandom_range(0, 3));
            fwd_wb_data   = {$urandom, $urandom};
            #1;
            checks++;
            if (in_ready !== ref_ready()) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, ref_ready());
            end
            model_step();
            tick();
            checks++;
            if (out_valid !== (held.size() == 1)) begin
                errors++;
                $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, out_valid, held.size() == 1);
            end else if (held.size() == 1) begin
                checks++;
                if (a !== held[0].a || b !== held[0].b || ALUControl !== held[0].ctrl ||
                    w_arith !== held[0].w || rd !== held[0].rd ||
                    reg_write !== held[0].rw || is_load !== held[0].ld) begin
                    errors++;
                    $display("FAIL rand_payload[%0d]: got a=%h b=%h c=%b w=%b rd=%0d rw=%b ld=%b expected a=%h b=%h c=%b w=%b rd=%0d rw=%b ld=%b",
                             i, a, b, ALUControl, w_arith, rd, reg_write, is_load,
                             held[0].a, held[0].b, held[0].ctrl, held[0].w,
                             held[0].rd, held[0].rw, held[0].ld);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_priority();
        test_load_use();
        test_w_op();
        test_backpressure_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the 64-bit integer ALU. It captures a decoded instruction, resolves operand forwarding (EX/MEM/WB), detects load-use hazards, and prepares 32-bit W-op shift operands. Its registered outputs drive the ALU operand, control and W-op inputs on the next cycle through a valid/ready handshake with stall and flush.

## Interface
- N, 64, datapath width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- rs1_addr, rs2_addr  in  5  source register indices
- rs1_data, rs2_data  in  N  register-file read data
- imm  in  N  sign-extended immediate
- alusrc  in  1  1: b = imm (rs2 unused); 0: b = rs2
- alu_ctrl_in  in  4  ALU opcode
- w_arith_in  in  1  32-bit W-op
- rd_in  in  5  destination index
- reg_write_in, is_load_in  in  1  writes rd / is a load
- flush  in  1  kill captured and incoming instruction
- ex_result  in  N  ALU result for the instruction held in this stage
- fwd_mem_valid  in  1;  fwd_mem_rd  in  5;  fwd_mem_data  in  N  MEM-stage writeback (load data included)
- fwd_wb_valid  in  1;  fwd_wb_rd  in  5;  fwd_wb_data  in  N  WB-stage writeback
- out_valid  out  1  outputs hold a live instruction
- out_ready  in  1  downstream accepts
- a, b  out  N  ALU operands
- ALUControl  out  4;  w_arith  out  1;  rd, reg_write, is_load  out  5/1/1  registered copies

## Operation
- Capture (all outputs registered) when in_valid && in_ready && !flush.
- in_ready = (!out_valid || out_ready) && !hazard, or 1 whenever flush = 1.
- hazard = out_valid && is_load && rd != 0 && (rs1_addr == rd || (!alusrc && rs2_addr == rd)).
- Next out_valid: flush → 0; else hazard && out_ready → 0 (bubble); else capture → 1; else out_valid && out_ready → 0; else hold.
- Forwarding per operand, evaluated at capture only, priority: EX > MEM > WB > register file.
  - EX: out_valid && reg_write && !is_load && rd == rsX → ex_result.
  - MEM: fwd_mem_valid && fwd_mem_rd == rsX; WB: fwd_wb_valid && fwd_wb_rd == rsX.
  - Index 0 never forwarded; rs == 0 yields rsX_data (0).
- b = alusrc ? imm : forwarded rs2.
- W-op prep on a when w_arith_in: alu_ctrl_in 0011 → a = {32'b0, rs1[31:0]}; 1011 → a = sign-extend rs1[31:0]; all others unmodified. Result sign-extension stays downstream of the ALU.
- Held instruction's outputs are stable while out_valid && !out_ready.

## Timing
- Reset (async): out_valid 0, a/b 0, ALUControl 0000, w_arith 0, rd 0, reg_write 0, is_load 0; in_ready 1 after reset release.
- Latency: 1 cycle from capture to out_valid.
- Throughput: 1 instruction/cycle with no hazard.
- Load-use: exactly one bubble cycle. Consumer is captured on the next cycle with MEM forward of load data.
- Flush dominates hazard, stall and capture. out_valid = 0 the following cycle.
- Reset mid-operation: outputs clear immediately. The in-flight instruction is lost.

## Test plan
- Pass-through: rs1_data=5, rs2_data=7, alu_ctrl_in=0010, no forwards → next cycle a=5, b=7, ALUControl=0010, out_valid=1.
- Priority: held addi x1 (ex_result=0x10), incoming add x2,x1,x1, MEM rd=1 data=0x20, WB rd=1 data=0x30 → a=b=0x10. With no EX match → 0x20. With only WB → 0x30.
- x0: MEM rd=0 data=0xFF, rs1=0 → a=0.
- Load-use: held ld x5, incoming add x6,x5,x1, out_ready=1 → in_ready=0, out_valid=0 next cycle. Following cycle add captured with fwd_mem rd=5 data=0xAB → a=0xAB. Same with alusrc=1 and rs2=5 → no hazard.
- W-op: rs1=0x0000_0000_8000_0000, w_arith, 1011 → a=0xFFFF_FFFF_8000_0000. rs1=0xFFFF_FFFF_8000_0010, 0011 → a=0x0000_0000_8000_0010.
- Backpressure, flush and reset: out_ready=0 for 3 cycles → outputs stable, in_ready=0. flush with in_valid=1 → out_valid=0 next cycle, nothing captured. reset asserted mid-hold → all outputs at reset values immediately.
